// File: rtl/ccff_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_pkg : register map, STATUS bit indices and FSM states of the        |
// | configuration-chain programmer. Revision 1.0                             |
// +--------------------------------------------------------------------------+
package ccff_pkg;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DATA   = 2'd2;
  localparam logic [1:0] REG_BITCNT = 2'd3;

  localparam int CTRL_START = 0;
  localparam int CTRL_ABORT = 1;
  localparam int CTRL_CLEAR = 2;

  localparam int ST_BUSY  = 0;
  localparam int ST_EMPTY = 1;
  localparam int ST_FULL  = 2;
  localparam int ST_DONE  = 3;
  localparam int ST_OVF   = 4;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT_LO = 3'd2,
    S_SHIFT_HI = 3'd3,
    S_DONE     = 3'd4
  } state_e;

endpackage
`default_nettype wire

// File: rtl/ccff_wb_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_wb_fifo : synchronous DEPTH x WIDTH FIFO with flush and concurrent  |
// | push/pop (a pop frees the slot for a same-cycle push). Revision 1.0      |
// +--------------------------------------------------------------------------+
module ccff_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q;
  logic [AW-1:0]    rptr_q;
  logic [AW:0]      count_q;
  logic             w_push;
  logic             w_pop;

  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rptr_q];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (flush_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (w_push) wptr_q <= wptr_q + AW'(1);
      if (w_pop)  rptr_q <= rptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !flush_i) mem_q[wptr_q] <= wdata_i;
  end

endmodule
`default_nettype wire

// File: rtl/ccff_wb_programmer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ccff_wb_programmer : Wishbone slave that streams FIFO words MSB-first    |
// | into a fabric configuration chain and captures the tail. Revision 1.0    |
// +--------------------------------------------------------------------------+
module ccff_wb_programmer
  import ccff_pkg::*;
#(
  parameter logic [31:0] BASE_ADR   = 32'h3000_0000,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_n_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_dat_i,
  input  logic [31:0] wbs_adr_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic        prog_clk_o,
  output logic        ccff_head_o,
  input  logic        ccff_tail_i,
  output logic        busy_o
);
  // Asynchronous assertion, release re-timed onto wb_clk_i.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) rst_sync_q <= 2'b00;
    else             rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_e      state_q;
  logic [31:0] shreg_q;
  logic [31:0] cap_q;
  logic [31:0] rem_q;
  logic [31:0] bitcnt_q;
  logic [5:0]  biw_q;
  logic        prog_clk_q;
  logic        busy_q;
  logic        done_q;
  logic        ovf_q;
  logic        ack_q;
  logic        pend_q;
  logic [31:0] dat_q;

  logic        w_sel, w_req, w_wr;
  logic [1:0]  w_reg;
  logic        w_ctrl_wr, w_start, w_abort, w_clear, w_push, w_pop;
  logic        w_done_set, w_ovf_set;
  logic        fifo_full, fifo_empty;
  logic [31:0] fifo_rdata;
  logic [31:0] w_rdata;
  logic        unused_adr;

  assign unused_adr = ^wbs_adr_i[1:0];

  // pend_q holds off a second ack while the master keeps the same strobe up.
  assign w_sel      = wbs_stb_i && wbs_cyc_i && (wbs_adr_i[31:4] == BASE_ADR[31:4]);
  assign w_req      = w_sel && !ack_q && !pend_q;
  assign w_reg      = wbs_adr_i[3:2];
  assign w_wr       = w_req && wbs_we_i;
  assign w_ctrl_wr  = w_wr && (w_reg == REG_CTRL);
  assign w_abort    = w_ctrl_wr && wbs_dat_i[CTRL_ABORT];
  assign w_start    = w_ctrl_wr && wbs_dat_i[CTRL_START] && !w_abort && !busy_q;
  assign w_clear    = w_ctrl_wr && wbs_dat_i[CTRL_CLEAR];
  assign w_push     = w_wr && (w_reg == REG_DATA);
  assign w_pop      = (state_q == S_LOAD) && !fifo_empty && !w_abort;
  assign w_ovf_set  = w_push && fifo_full && !w_pop;
  assign w_done_set = ((state_q == S_SHIFT_HI) && (rem_q == 32'd1) && !w_abort) ||
                      (w_start && (bitcnt_q == 32'd0));

  ccff_wb_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_n_i (rst_n),
    .flush_i (w_abort),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .wdata_i (wbs_dat_i),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    w_rdata = '0;
    case (w_reg)
      REG_STATUS: begin
        w_rdata[ST_BUSY]  = busy_q;
        w_rdata[ST_EMPTY] = fifo_empty;
        w_rdata[ST_FULL]  = fifo_full;
        w_rdata[ST_DONE]  = done_q;
        w_rdata[ST_OVF]   = ovf_q;
      end
      REG_DATA:   w_rdata = cap_q;
      REG_BITCNT: w_rdata = bitcnt_q;
      default:    w_rdata = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      ack_q    <= 1'b0;
      pend_q   <= 1'b0;
      dat_q    <= '0;
      bitcnt_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      ack_q <= w_req;
      dat_q <= (w_req && !wbs_we_i) ? w_rdata : 32'd0;
      if (w_req)                         pend_q <= 1'b1;
      else if (!(wbs_stb_i && wbs_cyc_i)) pend_q <= 1'b0;
      if (w_wr && (w_reg == REG_BITCNT) && !busy_q) begin
        for (int b = 0; b < 4; b++) begin
          if (wbs_sel_i[b]) bitcnt_q[8*b +: 8] <= wbs_dat_i[8*b +: 8];
        end
      end
      if (w_done_set)   done_q <= 1'b1;
      else if (w_clear) done_q <= 1'b0;
      if (w_ovf_set)    ovf_q  <= 1'b1;
      else if (w_clear) ovf_q  <= 1'b0;
    end
  end

  always_ff @(posedge wb_clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      shreg_q    <= '0;
      cap_q      <= '0;
      rem_q      <= '0;
      biw_q      <= '0;
      prog_clk_q <= 1'b0;
      busy_q     <= 1'b0;
    end else if (w_abort) begin
      state_q    <= S_IDLE;
      prog_clk_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          prog_clk_q <= 1'b0;
          if (w_start && (bitcnt_q != 32'd0)) begin
            state_q <= S_LOAD;
            rem_q   <= bitcnt_q;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_LOAD: begin
          if (!fifo_empty) begin
            shreg_q <= fifo_rdata;
            biw_q   <= 6'd32;
            state_q <= S_SHIFT_LO;
          end
        end
        S_SHIFT_LO: begin
          prog_clk_q <= 1'b1;
          state_q    <= S_SHIFT_HI;
        end
        S_SHIFT_HI: begin
          prog_clk_q <= 1'b0;
          cap_q      <= {cap_q[30:0], ccff_tail_i};
          shreg_q    <= {shreg_q[30:0], 1'b0};
          rem_q      <= rem_q - 32'd1;
          biw_q      <= biw_q - 6'd1;
          // Leftover bits of a partly used word are simply never shifted.
          if (rem_q == 32'd1) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
          end else if (biw_q == 6'd1) begin
            state_q <= S_LOAD;
          end else begin
            state_q <= S_SHIFT_LO;
          end
        end
        default: begin
          state_q    <= S_IDLE;
          prog_clk_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign wbs_ack_o   = ack_q;
  assign wbs_dat_o   = dat_q;
  assign prog_clk_o  = prog_clk_q;
  assign ccff_head_o = shreg_q[31];
  assign busy_o      = busy_q;

endmodule
`default_nettype wire
